// File: rtl/medium_pkg.sv
// Shared types for the medium (weight/heap BRAM) arbiter.
package medium_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  typedef enum logic {
    GRANT_CPU  = 1'b0,
    GRANT_HOST = 1'b1
  } grant_t;

  localparam int MAX_READ_LATENCY = 7;
  localparam int CNT_W            = $clog2(MAX_READ_LATENCY + 1);

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick: on a tie the requester opposite last_grant wins.
module rr_arbiter2
  import medium_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant,
  output logic       grant_valid
);

  grant_t pick;

  // req[0] is the CPU, req[1] is the host.
  always_comb begin
    pick = GRANT_CPU;
    case (req)
      2'b01:   pick = GRANT_CPU;
      2'b10:   pick = GRANT_HOST;
      2'b11:   pick = (grant_t'(last_grant) == GRANT_HOST) ? GRANT_CPU : GRANT_HOST;
      default: pick = GRANT_CPU;
    endcase
  end

  assign grant       = pick;
  assign grant_valid = |req;

endmodule

// File: rtl/medium_arbiter.sv
// Shares one single-port weight/heap BRAM between the CPU medium port and the host loader,
// serialising accesses, waiting out the BRAM read latency and holding returned data.
module medium_arbiter
  import medium_pkg::*;
#(
  parameter int  WORD_SIZE    = 1024,
  parameter int  DEPTH        = 256,
  parameter int  READ_LATENCY = 2,
  localparam int ADDR_SIZE    = $clog2(DEPTH)
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic [ADDR_SIZE-1:0] cpu_addr_in,
  input  logic                 cpu_read_enable_in,
  input  logic                 cpu_write_enable_in,
  input  logic [WORD_SIZE-1:0] cpu_data_in,
  output logic [WORD_SIZE-1:0] cpu_data_out,
  output logic                 cpu_finished_out,
  input  logic [ADDR_SIZE-1:0] host_addr_in,
  input  logic                 host_req_in,
  input  logic                 host_we_in,
  input  logic [WORD_SIZE-1:0] host_data_in,
  output logic [WORD_SIZE-1:0] host_data_out,
  output logic                 host_ack_out,
  output logic [ADDR_SIZE-1:0] bram_addr_out,
  output logic [WORD_SIZE-1:0] bram_data_out,
  output logic                 bram_en_out,
  output logic                 bram_we_out,
  input  logic [WORD_SIZE-1:0] bram_data_in,
  output logic                 protocol_error_out,
  output logic [1:0]           dbg_state
);

  // Handshakes: a CPU rd/wr pulse is a one-cycle request with no back-pressure, answered by
  // one cpu_finished_out pulse; the host holds req until a one-cycle ack. Both accesses are
  // committed at grant, so nothing after grant (including the host dropping req) cancels them.

  localparam logic [CNT_W-1:0] RD_WAIT = CNT_W'(READ_LATENCY - 1);

  arb_state_t             state;
  grant_t                 last_grant;
  grant_t                 cur_grant;
  logic                   cur_we;
  logic [CNT_W-1:0]       cnt;

  logic                   cpu_pulse;
  logic                   cpu_pending;
  logic                   cpu_we_q;
  logic [ADDR_SIZE-1:0]   cpu_addr_q;
  logic [WORD_SIZE-1:0]   cpu_wdata_q;

  logic                   cpu_req_eff;
  logic                   cpu_we_eff;
  logic [ADDR_SIZE-1:0]   cpu_addr_eff;
  logic [WORD_SIZE-1:0]   cpu_wdata_eff;

  logic                   arb_grant;
  logic                   arb_valid;
  grant_t                 arb_pick;

  assign cpu_pulse = cpu_read_enable_in | cpu_write_enable_in;

  // A fresh pulse is visible to arbitration in the cycle it arrives; once latched, the
  // latched copy wins and any further pulse is ignored.
  assign cpu_req_eff   = cpu_pending | cpu_pulse;
  assign cpu_we_eff    = cpu_pending ? cpu_we_q    : cpu_write_enable_in;
  assign cpu_addr_eff  = cpu_pending ? cpu_addr_q  : cpu_addr_in;
  assign cpu_wdata_eff = cpu_pending ? cpu_wdata_q : cpu_data_in;

  rr_arbiter2 u_rr (
    .req         ({host_req_in, cpu_req_eff}),
    .last_grant  (last_grant),
    .grant       (arb_grant),
    .grant_valid (arb_valid)
  );

  assign arb_pick  = grant_t'(arb_grant);
  assign dbg_state = state;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cpu_pending        <= 1'b0;
      cpu_we_q           <= 1'b0;
      cpu_addr_q         <= '0;
      cpu_wdata_q        <= '0;
      protocol_error_out <= 1'b0;
    end else begin
      if (cpu_read_enable_in && cpu_write_enable_in) begin
        protocol_error_out <= 1'b1;
      end
      if (cpu_pulse && cpu_pending) begin
        protocol_error_out <= 1'b1;
      end
      if (state == DONE && cur_grant == GRANT_CPU) begin
        cpu_pending <= 1'b0;
      end else if (cpu_pulse && !cpu_pending) begin
        cpu_pending <= 1'b1;
        cpu_we_q    <= cpu_write_enable_in;
        cpu_addr_q  <= cpu_addr_in;
        cpu_wdata_q <= cpu_data_in;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state            <= IDLE;
      last_grant       <= GRANT_HOST;
      cur_grant        <= GRANT_CPU;
      cur_we           <= 1'b0;
      cnt              <= '0;
      bram_en_out      <= 1'b0;
      bram_we_out      <= 1'b0;
      bram_addr_out    <= '0;
      bram_data_out    <= '0;
      cpu_data_out     <= '0;
      host_data_out    <= '0;
      cpu_finished_out <= 1'b0;
      host_ack_out     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_valid) begin
            state       <= ISSUE;
            last_grant  <= arb_pick;
            cur_grant   <= arb_pick;
            bram_en_out <= 1'b1;
            if (arb_pick == GRANT_CPU) begin
              cur_we        <= cpu_we_eff;
              bram_we_out   <= cpu_we_eff;
              bram_addr_out <= cpu_addr_eff;
              bram_data_out <= cpu_wdata_eff;
            end else begin
              cur_we        <= host_we_in;
              bram_we_out   <= host_we_in;
              bram_addr_out <= host_addr_in;
              bram_data_out <= host_data_in;
            end
          end
        end
        ISSUE: begin
          bram_en_out <= 1'b0;
          bram_we_out <= 1'b0;
          state       <= WAIT;
          // Writes spend a single recovery cycle in WAIT before completing.
          cnt         <= cur_we ? '0 : RD_WAIT;
        end
        WAIT: begin
          if (cnt == '0) begin
            if (!cur_we) begin
              if (cur_grant == GRANT_CPU) begin
                cpu_data_out <= bram_data_in;
              end else begin
                host_data_out <= bram_data_in;
              end
            end
            if (cur_grant == GRANT_CPU) begin
              cpu_finished_out <= 1'b1;
            end else begin
              host_ack_out <= 1'b1;
            end
            state <= DONE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        DONE: begin
          cpu_finished_out <= 1'b0;
          host_ack_out     <= 1'b0;
          state            <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_medium_arbiter.sv
// Bench for medium_arbiter: bench-side BRAM, cycle-level schedule model, directed scenarios.
module tb_medium_arbiter;
  import medium_pkg::*;

  localparam int W     = 16;
  localparam int DEPTH = 256;
  localparam int RL    = 2;
  localparam int A     = 8;

  logic         clk_in = 1'b0;
  logic         rst_in = 1'b1;
  logic [A-1:0] cpu_addr_in = '0;
  logic         cpu_read_enable_in = 1'b0;
  logic         cpu_write_enable_in = 1'b0;
  logic [W-1:0] cpu_data_in = '0;
  logic [W-1:0] cpu_data_out;
  logic         cpu_finished_out;
  logic [A-1:0] host_addr_in = '0;
  logic         host_req_in = 1'b0;
  logic         host_we_in = 1'b0;
  logic [W-1:0] host_data_in = '0;
  logic [W-1:0] host_data_out;
  logic         host_ack_out;
  logic [A-1:0] bram_addr_out;
  logic [W-1:0] bram_data_out;
  logic         bram_en_out;
  logic         bram_we_out;
  logic [W-1:0] bram_data_in;
  logic         protocol_error_out;
  logic [1:0]   dbg_state;

  medium_arbiter #(.WORD_SIZE(W), .DEPTH(DEPTH), .READ_LATENCY(RL)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .cpu_addr_in(cpu_addr_in), .cpu_read_enable_in(cpu_read_enable_in),
    .cpu_write_enable_in(cpu_write_enable_in), .cpu_data_in(cpu_data_in),
    .cpu_data_out(cpu_data_out), .cpu_finished_out(cpu_finished_out),
    .host_addr_in(host_addr_in), .host_req_in(host_req_in), .host_we_in(host_we_in),
    .host_data_in(host_data_in), .host_data_out(host_data_out), .host_ack_out(host_ack_out),
    .bram_addr_out(bram_addr_out), .bram_data_out(bram_data_out), .bram_en_out(bram_en_out),
    .bram_we_out(bram_we_out), .bram_data_in(bram_data_in),
    .protocol_error_out(protocol_error_out), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset / cycle count ----------------
  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test, want finish before 100000");
    $fatal(1, "watchdog");
  end

  // ---------------- bench BRAM with RL-cycle read latency ----------------
  function automatic logic [W-1:0] init_word(input int i);
    case (i)
      5:       return 16'h00A5;
      7:       return 16'h0077;
      default: return '0;
    endcase
  endfunction

  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] rd_pipe [RL];
  logic         loaded = 1'b0;

  always @(posedge clk_in) begin
    if (!loaded) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= init_word(i);
      loaded <= 1'b1;
    end else if (bram_en_out && bram_we_out) begin
      mem[bram_addr_out] <= bram_data_out;
    end
    rd_pipe[0] <= (bram_en_out && !bram_we_out) ? mem[bram_addr_out] : 16'hDEAD;
    for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign bram_data_in = rd_pipe[RL-1];

  // ---------------- check helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: got no completion pulse, want one within the cycle budget", name);
  endtask

  // ---------------- event monitor ----------------
  int   en_count = 0, fin_count = 0, ack_count = 0, last_en_cyc = -1;
  logic last_en_we = 1'b0;

  always @(negedge clk_in) begin
    if (!rst_in) begin
      if (bram_en_out) begin
        en_count    <= en_count + 1;
        last_en_cyc <= cyc;
        last_en_we  <= bram_we_out;
      end
      if (cpu_finished_out) fin_count <= fin_count + 1;
      if (host_ack_out)     ack_count <= ack_count + 1;
    end
  end

  // ---------------- schedule model + per-cycle compare ----------------
  // Each grant in cycle g books the BRAM: enable in g+1, completion in g+3 (write) or
  // g+2+RL (read); nothing new is granted until the cycle after completion.
  initial begin : model
    logic [W-1:0] model_mem [DEPTH];
    bit           m_busy, m_who, m_last, m_we, m_cpu_pend, m_cpu_we, m_err, pick;
    logic [A-1:0] m_addr, m_cpu_addr;
    logic [W-1:0] m_data, m_rd_val, m_cpu_data, m_cpu_q, m_host_q;
    int           m_issue, m_done, e_state;
    bit           e_en, e_done;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = init_word(i);
    forever begin
      @(negedge clk_in);
      if (rst_in) begin
        m_busy = 0; m_who = 0; m_last = 1; m_we = 0; m_cpu_pend = 0; m_cpu_we = 0; m_err = 0;
        m_addr = '0; m_cpu_addr = '0; m_data = '0; m_rd_val = '0; m_cpu_data = '0;
        m_cpu_q = '0; m_host_q = '0; m_issue = -1; m_done = -1;
        check("rst_strobes", 32'({bram_en_out, bram_we_out, cpu_finished_out, host_ack_out}), 32'(0));
        check("rst_data", 32'({cpu_data_out, host_data_out}), 32'(0));
        check("rst_err_state", 32'({protocol_error_out, dbg_state}), 32'(0));
      end else begin
        e_en   = m_busy && (cyc == m_issue);
        e_done = m_busy && (cyc == m_done);
        if (e_done && !m_we) begin
          if (m_who == 0) m_cpu_q = m_rd_val;
          else            m_host_q = m_rd_val;
        end
        e_state = !m_busy ? 0 : (cyc == m_issue) ? 1 : (cyc == m_done) ? 3 : 2;
        check("m_bram_en", 32'(bram_en_out), 32'(e_en));
        check("m_bram_we", 32'(bram_we_out), 32'(e_en && m_we));
        if (e_en) begin
          check("m_bram_addr", 32'(bram_addr_out), 32'(m_addr));
          if (m_we) check("m_bram_wdata", 32'(bram_data_out), 32'(m_data));
        end
        check("m_cpu_finished", 32'(cpu_finished_out), 32'(e_done && m_who == 0));
        check("m_host_ack", 32'(host_ack_out), 32'(e_done && m_who == 1));
        check("m_cpu_data", 32'(cpu_data_out), 32'(m_cpu_q));
        check("m_host_data", 32'(host_data_out), 32'(m_host_q));
        check("m_proto_err", 32'(protocol_error_out), 32'(m_err));
        check("m_state", 32'(dbg_state), 32'(e_state));

        // advance the model with this cycle's inputs
        if (cpu_read_enable_in && cpu_write_enable_in) m_err = 1;
        if (cpu_read_enable_in || cpu_write_enable_in) begin
          if (m_cpu_pend) m_err = 1;
          else begin
            m_cpu_pend = 1; m_cpu_we = cpu_write_enable_in;
            m_cpu_addr = cpu_addr_in; m_cpu_data = cpu_data_in;
          end
        end
        if (e_done) begin
          if (m_who == 0) m_cpu_pend = 0;
          m_busy = 0;
        end else if (!m_busy && (m_cpu_pend || host_req_in)) begin
          if (m_cpu_pend && host_req_in) pick = !m_last;
          else                           pick = !m_cpu_pend;
          m_who = pick; m_last = pick; m_busy = 1; m_issue = cyc + 1;
          if (pick == 0) begin
            m_we = m_cpu_we; m_addr = m_cpu_addr; m_data = m_cpu_data;
          end else begin
            m_we = host_we_in; m_addr = host_addr_in; m_data = host_data_in;
          end
          m_done = m_we ? cyc + 3 : cyc + 2 + RL;
          if (m_we) model_mem[m_addr] = m_data;
          else      m_rd_val = model_mem[m_addr];
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic cpu_pulse(input logic rd, input logic wr, input logic [A-1:0] a,
                           input logic [W-1:0] d);
    cpu_read_enable_in  = rd;
    cpu_write_enable_in = wr;
    cpu_addr_in         = a;
    cpu_data_in         = d;
    tick();
    cpu_read_enable_in  = 1'b0;
    cpu_write_enable_in = 1'b0;
  endtask

  task automatic wait_cpu_fin(input string name, output int fc, output logic [W-1:0] d);
    fc = -1;
    d  = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_in);
      if (cpu_finished_out) begin
        fc = cyc;
        d  = cpu_data_out;
        break;
      end
    end
    if (fc < 0) fail_now(name);
    tick();
  endtask

  task automatic host_access(input string name, input logic we, input logic [A-1:0] a,
                             input logic [W-1:0] d, output int ac, output logic [W-1:0] q);
    host_req_in  = 1'b1;
    host_we_in   = we;
    host_addr_in = a;
    host_data_in = d;
    ac = -1;
    q  = '0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_in);
      if (host_ack_out) begin
        ac = cyc;
        q  = host_data_out;
        break;
      end
    end
    if (ac < 0) fail_now(name);
    tick();
    host_req_in = 1'b0;
    host_we_in  = 1'b0;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin : stim
    int t, fc, ac, e0, f0, a0;
    logic [W-1:0] dc, dh;

    repeat (3) tick();
    check("reset_cpu_data", 32'(cpu_data_out), 32'(0));
    check("reset_state", 32'(dbg_state), 32'(IDLE));
    rst_in = 1'b0;
    tick();

    // 1: uncontended CPU read
    t = cyc;
    cpu_pulse(1'b1, 1'b0, 8'd5, '0);
    wait_cpu_fin("t1_wait", fc, dc);
    check("t1_en_cycle", 32'(last_en_cyc - t), 32'(1));
    check("t1_fin_latency", 32'(fc - t), 32'(4));
    check("t1_data", 32'(dc), 32'h00A5);
    repeat (3) tick();
    check("t1_data_held", 32'(cpu_data_out), 32'h00A5);

    // 2: CPU write, then host readback
    t  = cyc;
    e0 = en_count;
    cpu_pulse(1'b0, 1'b1, 8'd3, 16'h003C);
    wait_cpu_fin("t2_wait", fc, dc);
    check("t2_fin_latency", 32'(fc - t), 32'(3));
    check("t2_en_once", 32'(en_count - e0), 32'(1));
    check("t2_en_cycle", 32'(last_en_cyc - t), 32'(1));
    check("t2_en_we", 32'(last_en_we), 32'(1));
    t = cyc;
    host_access("t2_host", 1'b0, 8'd3, '0, ac, dh);
    check("t2_host_latency", 32'(ac - t), 32'(4));
    check("t2_host_data", 32'(dh), 32'h003C);

    // 3a: tie after a host grant -> CPU first
    t = cyc;
    fork
      begin
        cpu_pulse(1'b1, 1'b0, 8'd5, '0);
        wait_cpu_fin("t3a_cpu", fc, dc);
      end
      host_access("t3a_host", 1'b0, 8'd3, '0, ac, dh);
    join
    check("t3a_cpu_first", 32'(fc - t), 32'(4));
    check("t3a_host_next", 32'(ac - t), 32'(9));
    check("t3a_cpu_data", 32'(dc), 32'h00A5);
    check("t3a_host_data", 32'(dh), 32'h003C);

    // 3b: CPU-only access, then a tie -> host first
    cpu_pulse(1'b1, 1'b0, 8'd7, '0);
    wait_cpu_fin("t3b_solo", fc, dc);
    check("t3b_solo_data", 32'(dc), 32'h0077);
    t = cyc;
    fork
      begin
        cpu_pulse(1'b1, 1'b0, 8'd3, '0);
        wait_cpu_fin("t3b_cpu", fc, dc);
      end
      host_access("t3b_host", 1'b0, 8'd5, '0, ac, dh);
    join
    check("t3b_host_first", 32'(ac - t), 32'(4));
    check("t3b_cpu_next", 32'(fc - t), 32'(9));
    check("t3b_host_data", 32'(dh), 32'h00A5);
    check("t3b_cpu_data", 32'(dc), 32'h003C);

    // 4: CPU pulse arrives during a host read
    t = cyc;
    fork
      host_access("t4_host", 1'b0, 8'd7, '0, ac, dh);
      begin
        tick();
        tick();
        cpu_pulse(1'b1, 1'b0, 8'd5, '0);
        wait_cpu_fin("t4_cpu", fc, dc);
      end
    join
    check("t4_host_ack", 32'(ac - t), 32'(4));
    check("t4_cpu_after_host", 32'(fc - t), 32'(9));
    check("t4_host_data", 32'(dh), 32'h0077);
    check("t4_cpu_data", 32'(dc), 32'h00A5);
    check("t4_no_error", 32'(protocol_error_out), 32'(0));

    // 5: read and write together -> write only, error flagged
    t  = cyc;
    e0 = en_count;
    f0 = fin_count;
    cpu_pulse(1'b1, 1'b1, 8'd9, 16'h0099);
    wait_cpu_fin("t5_wait", fc, dc);
    check("t5_fin_latency", 32'(fc - t), 32'(3));
    repeat (4) tick();
    check("t5_one_access", 32'(en_count - e0), 32'(1));
    check("t5_access_is_write", 32'(last_en_we), 32'(1));
    check("t5_one_finish", 32'(fin_count - f0), 32'(1));
    check("t5_error_set", 32'(protocol_error_out), 32'(1));
    cpu_pulse(1'b1, 1'b0, 8'd9, '0);
    wait_cpu_fin("t5_readback", fc, dc);
    check("t5_readback_data", 32'(dc), 32'h0099);

    // 6: reset in the middle of a CPU read
    t = cyc;
    cpu_pulse(1'b1, 1'b0, 8'd5, '0);
    tick();
    #2;
    rst_in = 1'b1;
    #1;
    f0 = fin_count;
    a0 = ack_count;
    check("t6_async_cpu_data", 32'(cpu_data_out), 32'(0));
    check("t6_async_err", 32'(protocol_error_out), 32'(0));
    check("t6_async_state", 32'(dbg_state), 32'(IDLE));
    check("t6_async_strobes", 32'({bram_en_out, cpu_finished_out, host_ack_out}), 32'(0));
    tick();
    tick();
    rst_in = 1'b0;
    repeat (6) tick();
    check("t6_no_finish", 32'(fin_count - f0), 32'(0));
    check("t6_no_ack", 32'(ack_count - a0), 32'(0));
    t = cyc;
    cpu_pulse(1'b1, 1'b0, 8'd3, '0);
    wait_cpu_fin("t6_after_reset", fc, dc);
    check("t6_fin_latency", 32'(fc - t), 32'(4));
    check("t6_data", 32'(dc), 32'h003C);

    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
